bsg_cache_sbuf_deep: RTL

//  Parametrised-depth store buffer for the bsg_cache store path, generalising the fixed 2-entry sbuf.

---
 rtl/bsg_cache_sbuf_deep.sv | 139 +++++++++++++
 1 files changed

// File: rtl/bsg_cache_sbuf_deep.sv
// bsg_cache_sbuf_deep: parametrised-depth store buffer for the bsg_cache store path.
// Pending stores sit in a circular queue and drain oldest-first to the data-mem write
// port. A per-byte load-bypass lookup merges all valid entries plus the entering store,
// with the youngest matching write winning each byte.
//
// Ports:
//   clk_i, reset_i        clock, async active-high reset
//   sbuf_entry_i, v_i     entering store {addr, data, mask, way_id}; accepted when ready_o
//   ready_o               space available (num_els < els_p)
//   sbuf_entry_o, v_o     oldest entry (or entering store when empty), valid
//   yumi_i                consumer takes sbuf_entry_o this cycle
//   empty_o, full_o       occupancy flags
//   bypass_addr_i/_v_i    load address and lookup strobe
//   bypass_data_o/_mask_o registered merged bypass data and byte-valid mask
module bsg_cache_sbuf_deep #(
  parameter int unsigned data_width_p = 32,
  parameter int unsigned addr_width_p = 28,
  parameter int unsigned ways_p       = 2,
  parameter int unsigned els_p        = 4,
  localparam int unsigned lg_ways     = (ways_p > 1) ? $clog2(ways_p) : 1,
  localparam int unsigned mask_w      = data_width_p / 8,
  localparam int unsigned ew          = addr_width_p + data_width_p + mask_w + lg_ways
) (
  input  logic                    clk_i,
  input  logic                    reset_i,
  input  logic [ew-1:0]           sbuf_entry_i,
  input  logic                    v_i,
  output logic                    ready_o,
  output logic [ew-1:0]           sbuf_entry_o,
  output logic                    v_o,
  input  logic                    yumi_i,
  output logic                    empty_o,
  output logic                    full_o,
  input  logic [addr_width_p-1:0] bypass_addr_i,
  input  logic                    bypass_v_i,
  output logic [data_width_p-1:0] bypass_data_o,
  output logic [mask_w-1:0]       bypass_mask_o
);

  localparam int unsigned lg_els   = $clog2(els_p);
  localparam int unsigned lg_bytes = (mask_w > 1) ? $clog2(mask_w) : 0;

  logic [ew-1:0]     mem [els_p];
  logic [lg_els-1:0] rd_ptr;
  logic [lg_els-1:0] wr_ptr;
  logic [lg_els:0]   num_els;

  logic empty;
  logic full;
  logic enq;
  logic deq;
  logic pop;
  logic store;

  // Queue status and handshake
  assign empty        = (num_els == '0);
  assign full         = (num_els == (lg_els+1)'(els_p));
  assign ready_o      = ~full;
  assign empty_o      = empty;
  assign full_o       = full;
  assign v_o          = empty ? v_i : 1'b1;
  assign sbuf_entry_o = empty ? sbuf_entry_i : mem[rd_ptr];

  // deq is qualified by v_o so an illegal yumi leaves the state untouched.
  // An entering store consumed on the same cycle while empty bypasses storage.
  assign enq   = v_i & ~full;
  assign deq   = yumi_i & v_o;
  assign pop   = deq & ~empty;
  assign store = enq & ~(empty & deq);

  // Pointers and occupancy
  always_ff @(posedge clk_i or posedge reset_i) begin
    if (reset_i) begin
      rd_ptr  <= '0;
      wr_ptr  <= '0;
      num_els <= '0;
    end else begin
      if (store) wr_ptr <= wr_ptr + lg_els'(1);
      if (pop)   rd_ptr <= rd_ptr + lg_els'(1);
      num_els <= num_els + (lg_els+1)'(store) - (lg_els+1)'(pop);
    end
  end

  // Entry storage (not reset)
  always_ff @(posedge clk_i) begin
    if (store) mem[wr_ptr] <= sbuf_entry_i;
  end

  function automatic logic tag_hit(input logic [ew-1:0] e, input logic [addr_width_p-1:0] a);
    return (e[ew-1 -: addr_width_p] >> lg_bytes) == (a >> lg_bytes);
  endfunction

  // Candidates ordered by age: index 0 oldest queued, index els_p is the entering store
  logic [ew-1:0] cand [els_p+1];
  logic [els_p:0] cand_hit;

  always_comb begin
    for (int unsigned i = 0; i < els_p; i++) begin
      cand[i]     = mem[rd_ptr + lg_els'(i)];
      cand_hit[i] = ((lg_els+1)'(i) < num_els) && tag_hit(mem[rd_ptr + lg_els'(i)], bypass_addr_i);
    end
    cand[els_p]     = sbuf_entry_i;
    cand_hit[els_p] = v_i && tag_hit(sbuf_entry_i, bypass_addr_i);
  end

  logic [data_width_p-1:0] data_n;
  logic [mask_w-1:0]       mask_n;

  // Byte merge: scanning oldest to youngest lets younger writes overwrite older ones
  always_comb begin
    data_n = '0;
    mask_n = '0;
    for (int unsigned i = 0; i <= els_p; i++) begin
      if (cand_hit[i]) begin
        for (int unsigned b = 0; b < mask_w; b++) begin
          if (cand[i][lg_ways+b]) begin
            mask_n[b]        = 1'b1;
            data_n[8*b +: 8] = cand[i][lg_ways+mask_w+8*b +: 8];
          end
        end
      end
    end
  end

  // Bypass result register; holds when no lookup is requested
  always_ff @(posedge clk_i or posedge reset_i) begin
    if (reset_i) begin
      bypass_data_o <= '0;
      bypass_mask_o <= '0;
    end else if (bypass_v_i) begin
      bypass_data_o <= data_n;
      bypass_mask_o <= mask_n;
    end
  end

  // Consumer must never take an entry that is not valid
  yumi_only_when_valid: assert property (@(posedge clk_i) disable iff (reset_i) !(yumi_i && !v_o));

endmodule
